// File: rtl/password_enroll_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// password_enroll_if : switch/button inputs and status/code outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface password_enroll_if #(
   parameter int DIGITS = 4
);
   logic [9:0]          Sw;
   logic                btn_n;
   logic [4*DIGITS-1:0] code_out;
   logic                code_update;
   logic [9:0]          leds_out;
   logic [0:6]          seg0_out;
   logic [0:6]          seg1_out;
   logic [0:6]          seg2_out;
   logic [0:6]          seg3_out;
   logic [0:6]          seg4_out;

   modport master (
      output Sw, btn_n,
      input  code_out, code_update, leds_out,
      input  seg0_out, seg1_out, seg2_out, seg3_out, seg4_out
   );

   modport slave (
      input  Sw, btn_n,
      output code_out, code_update, leds_out,
      output seg0_out, seg1_out, seg2_out, seg3_out, seg4_out
   );
endinterface
`default_nettype wire

// File: rtl/password_enroll.sv
`default_nettype none
// ---------------------------------------------------------------------------
// password_enroll : debounced two-pass BCD password enrollment with LED/7-seg status
// Rev 1.0
// ---------------------------------------------------------------------------
module password_enroll #(
   parameter int                  DIGITS          = 4,
   parameter int                  DEBOUNCE_CYCLES = 500000,
   parameter logic [4*DIGITS-1:0] DEFAULT_CODE    = 16'h1234
) (
   input  logic              clk,
   input  logic              rst,
   password_enroll_if.slave  bus
);
   localparam int W   = 4 * DIGITS;
   localparam int CW  = $clog2(DIGITS + 1);
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ENTER   = 3'd1;
   localparam logic [2:0] S_CONFIRM = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_FAIL    = 3'd4;

   localparam logic [0:6] SEG_BLANK = 7'b1111111;
   localparam logic [0:6] SEG_DASH  = 7'b1111110;

   function automatic logic [0:6] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   logic           sync1_q, sync2_q, db_q, db_d, press_q, press_d;
   logic [DBW-1:0] dbcnt_q, dbcnt_d;
   logic [2:0]     state_q, state_d;
   logic [W-1:0]   buf_a_q, buf_a_d, buf_b_q, buf_b_d, code_q, code_d, nb;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
   logic           upd_q, upd_d;
   logic [9:0]     leds_q, leds_d;
   logic [0:6]     seg_q [0:4];
   logic [0:6]     seg_d [0:4];
   logic [3:0]     digit;
   logic           en, dig_ok, last;
   logic           unused_sw;

   assign unused_sw = ^bus.Sw[8:4];
   assign digit     = bus.Sw[3:0];
   assign en        = bus.Sw[9];

   // Stability counter only runs while the synchronized level disagrees with the accepted one
   always_comb begin
      db_d    = db_q;
      dbcnt_d = '0;
      if (sync2_q != db_q) begin
         if (dbcnt_q == DB_LAST) db_d = sync2_q;
         else                    dbcnt_d = dbcnt_q + 1'b1;
      end
      press_d = db_q & ~db_d;
   end

   always_comb begin
      state_d = state_q;
      buf_a_d = buf_a_q;
      buf_b_d = buf_b_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      upd_d   = 1'b0;
      dig_ok  = press_q && (digit <= 4'd9);
      cnt_inc = cnt_q + 1'b1;
      last    = (cnt_inc == CW'(DIGITS));
      nb      = (buf_b_q << 4) | W'(digit);
      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_ENTER;
               buf_a_d = '0;
               buf_b_d = '0;
               cnt_d   = '0;
            end
         end
         S_ENTER, S_CONFIRM: begin
            if (!en) begin
               state_d = S_IDLE;
               buf_a_d = '0;
               buf_b_d = '0;
               cnt_d   = '0;
            end else if (dig_ok) begin
               cnt_d = last ? '0 : cnt_inc;
               if (state_q == S_ENTER) begin
                  buf_a_d = (buf_a_q << 4) | W'(digit);
                  if (last) state_d = S_CONFIRM;
               end else begin
                  buf_b_d = nb;
                  if (last) begin
                     if (nb == buf_a_q) begin
                        code_d  = buf_a_q;
                        upd_d   = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        state_d = S_FAIL;
                     end
                  end
               end
            end
         end
         S_DONE, S_FAIL: begin
            if (!en) begin
               state_d = S_IDLE;
               buf_a_d = '0;
               buf_b_d = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Display/LED images are built from next-state values so they register in step with the FSM
   always_comb begin
      logic [W-1:0] shown;
      int           nib;
      leds_d    = '0;
      shown     = (state_d == S_ENTER) ? buf_a_d : buf_b_d;
      nib       = 0;
      for (int i = 0; i < DIGITS; i++) leds_d[i] = (CW'(i) < cnt_d);
      leds_d[9] = (state_d == S_ENTER) || (state_d == S_CONFIRM);
      leds_d[8] = (state_d == S_DONE);
      leds_d[7] = (state_d == S_FAIL);
      case (state_d)
         S_ENTER:   seg_d[0] = 7'b0110000;
         S_CONFIRM: seg_d[0] = 7'b0110001;
         S_DONE:    seg_d[0] = 7'b1000010;
         S_FAIL:    seg_d[0] = 7'b0111000;
         default:   seg_d[0] = SEG_BLANK;
      endcase
      for (int j = 0; j < 4; j++) begin
         seg_d[j+1] = SEG_BLANK;
         if (j < DIGITS) begin
            if ((state_d == S_ENTER) || (state_d == S_CONFIRM)) begin
               if (CW'(j) < cnt_d) begin
                  nib        = int'(cnt_d) - 1 - j;
                  seg_d[j+1] = seg7(shown[nib*4 +: 4]);
               end
            end else if (state_d == S_DONE) begin
               seg_d[j+1] = seg7(code_d[(DIGITS-1-j)*4 +: 4]);
            end else if (state_d == S_FAIL) begin
               seg_d[j+1] = SEG_DASH;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         db_q    <= 1'b1;
         dbcnt_q <= '0;
         press_q <= 1'b0;
         state_q <= S_IDLE;
         buf_a_q <= '0;
         buf_b_q <= '0;
         cnt_q   <= '0;
         code_q  <= DEFAULT_CODE;
         upd_q   <= 1'b0;
         leds_q  <= '0;
         for (int k = 0; k < 5; k++) seg_q[k] <= SEG_BLANK;
      end else begin
         sync1_q <= bus.btn_n;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         dbcnt_q <= dbcnt_d;
         press_q <= press_d;
         state_q <= state_d;
         buf_a_q <= buf_a_d;
         buf_b_q <= buf_b_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         upd_q   <= upd_d;
         leds_q  <= leds_d;
         for (int k = 0; k < 5; k++) seg_q[k] <= seg_d[k];
      end
   end

   assign bus.code_out    = code_q;
   assign bus.code_update = upd_q;
   assign bus.leds_out    = leds_q;
   assign bus.seg0_out    = seg_q[0];
   assign bus.seg1_out    = seg_q[1];
   assign bus.seg2_out    = seg_q[2];
   assign bus.seg3_out    = seg_q[3];
   assign bus.seg4_out    = seg_q[4];
endmodule
`default_nettype wire

// File: tb/tb_password_enroll.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_password_enroll : directed enrollment scenarios with a commit scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_password_enroll;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] exp_q [$];

   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_DASH  = 7'b1111110;
   localparam logic [6:0] G_E     = 7'b0110000;
   localparam logic [6:0] G_C     = 7'b0110001;
   localparam logic [6:0] G_D     = 7'b1000010;
   localparam logic [6:0] G_F     = 7'b0111000;

   password_enroll_if #(.DIGITS(4)) bus ();

   password_enroll #(
      .DIGITS(4), .DEBOUNCE_CYCLES(4), .DEFAULT_CODE(16'h1234)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dig(input int d);
      case (d)
         0: dig = 7'b0000001;  1: dig = 7'b1001111;
         2: dig = 7'b0010010;  3: dig = 7'b0000110;
         4: dig = 7'b1001100;  5: dig = 7'b0100100;
         6: dig = 7'b0100000;  7: dig = 7'b0001111;
         8: dig = 7'b0000000;  9: dig = 7'b0000100;
         default: dig = G_BLANK;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] d);
      bus.Sw[3:0] = d;
      bus.btn_n   = 1'b0;
      cyc(10);
      bus.btn_n   = 1'b1;
      cyc(10);
   endtask

   task automatic chk_segs(input string name, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input logic [6:0] s4);
      chk({name, "_seg0"}, 32'(bus.seg0_out), 32'(s0));
      chk({name, "_seg1"}, 32'(bus.seg1_out), 32'(s1));
      chk({name, "_seg2"}, 32'(bus.seg2_out), 32'(s2));
      chk({name, "_seg3"}, 32'(bus.seg3_out), 32'(s3));
      chk({name, "_seg4"}, 32'(bus.seg4_out), 32'(s4));
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_code"}, 32'(bus.code_out), 32'h1234);
      chk({name, "_upd"},  32'(bus.code_update), 32'h0);
      chk({name, "_leds"}, 32'(bus.leds_out), 32'h0);
      chk_segs(name, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK);
   endtask

   // Commit scoreboard: every code_update must match the next queued expectation
   always @(negedge clk) begin
      if (rst && bus.code_update) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected got code_out=%h expected no code_update", bus.code_out);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (bus.code_out !== e) begin
               errors++;
               $display("FAIL commit_code got=%h expected=%h", bus.code_out, e);
            end
         end
         checks++;
         if (bus.leds_out[8] !== 1'b1) begin
            errors++;
            $display("FAIL commit_done_led got=%b expected=1", bus.leds_out[8]);
         end
      end
   end

   initial begin
      bus.Sw    = '0;
      bus.btn_n = 1'b1;
      cyc(3);
      chk_reset("in_reset");
      rst = 1'b1;
      cyc(2);
      chk_reset("after_reset");

      // Enroll 5678 twice
      bus.Sw[9] = 1'b1;
      cyc(2);
      chk("enter_seg0", 32'(bus.seg0_out), 32'(G_E));
      chk("enter_leds", 32'(bus.leds_out), 32'h200);
      press(5); press(6); press(7);
      chk("enter3_leds", 32'(bus.leds_out), 32'h207);
      chk_segs("enter3", G_E, dig(5), dig(6), dig(7), G_BLANK);
      press(8);
      chk("confirm_leds", 32'(bus.leds_out), 32'h200);
      chk_segs("confirm0", G_C, G_BLANK, G_BLANK, G_BLANK, G_BLANK);
      press(5); press(6); press(7);
      exp_q.push_back(16'h5678);
      press(8);
      chk("done_leds", 32'(bus.leds_out), 32'h100);
      chk("done_code", 32'(bus.code_out), 32'h5678);
      chk_segs("done", G_D, dig(5), dig(6), dig(7), dig(8));

      // Mismatched confirmation
      bus.Sw[9] = 1'b0;
      cyc(2);
      chk("idle_leds", 32'(bus.leds_out), 32'h0);
      bus.Sw[9] = 1'b1;
      cyc(2);
      press(1); press(2); press(3); press(4);
      press(1); press(2); press(3); press(5);
      chk("fail_leds", 32'(bus.leds_out), 32'h080);
      chk("fail_code", 32'(bus.code_out), 32'h5678);
      chk_segs("fail", G_F, G_DASH, G_DASH, G_DASH, G_DASH);

      // Invalid digit ignored
      bus.Sw[9] = 1'b0;
      cyc(2);
      bus.Sw[9] = 1'b1;
      cyc(2);
      press(2);
      chk("one_leds", 32'(bus.leds_out), 32'h201);
      press(4'hC);
      chk("bad_digit_leds", 32'(bus.leds_out), 32'h201);
      chk_segs("bad_digit", G_E, dig(2), G_BLANK, G_BLANK, G_BLANK);

      // Short glitch, then a timed valid hold
      bus.Sw[3:0] = 4'd3;
      bus.btn_n   = 1'b0;
      cyc(3);
      bus.btn_n   = 1'b1;
      cyc(10);
      chk("glitch_leds", 32'(bus.leds_out), 32'h201);
      bus.btn_n = 1'b0;
      cyc(6);
      chk("hold_early_leds", 32'(bus.leds_out), 32'h201);
      cyc(1);
      chk("hold_capture_leds", 32'(bus.leds_out), 32'h203);
      chk("hold_capture_seg2", 32'(bus.seg2_out), 32'(dig(3)));
      bus.btn_n = 1'b1;
      cyc(10);
      chk("release_leds", 32'(bus.leds_out), 32'h203);

      // Abort after two confirm digits
      press(4); press(4);
      press(2); press(3);
      chk("confirm2_leds", 32'(bus.leds_out), 32'h203);
      chk("confirm2_seg0", 32'(bus.seg0_out), 32'(G_C));
      bus.Sw[9] = 1'b0;
      cyc(1);
      chk("abort_leds", 32'(bus.leds_out), 32'h0);
      chk("abort_seg0", 32'(bus.seg0_out), 32'(G_BLANK));
      chk("abort_code", 32'(bus.code_out), 32'h5678);

      // Final confirm press coinciding with enable drop: no commit
      bus.Sw[9] = 1'b1;
      cyc(2);
      press(9); press(9); press(9); press(9);
      press(9); press(9); press(9);
      bus.btn_n = 1'b0;
      cyc(6);
      bus.Sw[9] = 1'b0;
      cyc(2);
      bus.btn_n = 1'b1;
      cyc(10);
      chk("abort_press_leds", 32'(bus.leds_out), 32'h0);
      chk("abort_press_code", 32'(bus.code_out), 32'h5678);

      // Asynchronous reset mid-entry
      bus.Sw[9] = 1'b1;
      cyc(2);
      press(7);
      chk("pre_rst_leds", 32'(bus.leds_out), 32'h201);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk_reset("async_rst");
      @(negedge clk);
      rst = 1'b1;
      cyc(2);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/password_enroll.md
# password_enroll

Switch-and-button enrollment front end that writes a new 4-digit BCD password for the `password` checker. It debounces a push button and captures digits from the switches. It requires the same code to be entered twice before committing it. It shows progress on LEDs and five active-low 7-segment displays. It sits beside `password` on the DE10-Lite board, on the same 50 MHz clock and KEY[0] reset, and drives the checker's stored-code input.

## Interface
- `DIGITS`, 4: number of BCD digits in the password.
- `DEBOUNCE_CYCLES`, 500000: cycles the synchronized button must be stable before it is accepted (10 ms at 50 MHz).
- `DEFAULT_CODE`, 16'h1234: password loaded at reset. The first digit is the most significant nibble.
- `clk` in 1: system clock, MAX10_CLK1_50.
- `rst` in 1: asynchronous, active-low reset (KEY[0]).
- `Sw` in 10: `Sw[3:0]` is the digit value; `Sw[9]` is the enroll enable; `Sw[8:4]` are ignored.
- `btn_n` in 1: raw push button (KEY[1]), active-low, asynchronous to `clk`.
- `code_out` out 4*DIGITS: the committed password in BCD.
- `code_update` out 1: one-cycle pulse in the cycle `code_out` takes a new value.
- `leds_out` out 10: status LEDs.
- `seg0_out`..`seg4_out` out 7 each: indexed [0:6] = segments a..g, active-low. `seg0_out` is the leftmost display.

## Operation
- Button path:
  - 2-flop synchronizer on `btn_n`.
  - Stability counter: resets whenever the synchronized value equals the debounced value.
  - When the counter reaches `DEBOUNCE_CYCLES`-1, the debounced value flips.
  - `press` is a one-cycle pulse on a debounced 1->0 transition. Release generates nothing.
- FSM states: IDLE, ENTER, CONFIRM, DONE, FAIL. The reset state is IDLE.
- IDLE:
  - `press` is ignored.
  - When `Sw[9]`=1, go to ENTER; clear `buf_a`, `buf_b` and the digit count.
- ENTER:
  - On `press` with `Sw[3:0]`<=9, shift the digit into `buf_a` and increment the count.
  - On `press` with `Sw[3:0]`>9, nothing is captured and the count is unchanged.
  - When the count reaches `DIGITS`, go to CONFIRM with the count cleared.
- CONFIRM:
  - Digits are captured into `buf_b` under the same rules as ENTER.
  - On the press that captures the last digit, compare `{buf_b, new digit}` with `buf_a`.
  - Equal: load `code_out` from `buf_a`, pulse `code_update`, go to DONE.
  - Not equal: go to FAIL; `code_out` is unchanged.
- DONE and FAIL hold their state until `Sw[9]`=0, then return to IDLE.
- Abort: `Sw[9]`=0 in ENTER or CONFIRM returns to IDLE the next cycle. Buffers are cleared and `code_out` is unchanged.
- `leds_out`:
  - [`DIGITS`-1:0] is a thermometer of the digits entered in the current phase.
  - [9] = ENTER or CONFIRM.
  - [8] = DONE.
  - [7] = FAIL.
  - All other bits are 0.
- `seg0_out` (status glyph):
  - IDLE: blank.
  - ENTER: 'E'.
  - CONFIRM: 'C'.
  - DONE: 'd'.
  - FAIL: 'F'.
- `seg1_out`..`seg4_out` (digit 1 leftmost):
  - ENTER: entered digits of `buf_a`.
  - CONFIRM: entered digits of `buf_b`.
  - Positions not yet entered are blank.
  - DONE: `code_out`.
  - FAIL: '-' on all four.
  - IDLE: blank.
- Segment codes: active-low, a..g. Blank = 7'b1111111. '-' = 7'b1111110. Digits 0-9 use the standard patterns.
- All outputs are registered.

## Timing
- Reset values:
  - State IDLE; buffers and count 0.
  - `code_out` = `DEFAULT_CODE`, `code_update` = 0.
  - `leds_out` = 0; all segment outputs 7'b1111111.
  - Debounced button = 1; stability counter = 0.
- Press latency: `btn_n` goes and stays low at edge t. The synchronized value is low at t+2. `press` is high in cycle t+2+`DEBOUNCE_CYCLES`.
- The digit is captured, and count/LEDs/display update, at the edge ending the `press` cycle. `Sw[3:0]` is sampled in the `press` cycle.
- `code_update` and the new `code_out` appear 1 cycle after the final `press`. The state is DONE in that same cycle.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no `press`.
- Simultaneous events:
  - `press` in the same cycle as `Sw[9]` falling: abort wins and the digit is discarded.
  - Final confirm `press` with `Sw[9]`=0: abort wins, no commit.
- Asynchronous reset mid-entry: immediately restores the reset values, including `code_out` = `DEFAULT_CODE`.

## Test plan
Run with `DEBOUNCE_CYCLES`=4.

1. Release reset.
   - `code_out`=16'h1234, `leds_out`=0, all segments 7'b1111111, `code_update`=0.
2. Set `Sw[9]`=1 and press with `Sw[3:0]`=5,6,7,8, then 5,6,7,8 again.
   - After the 4th press: `seg0_out`='C'.
   - One cycle after the 8th press: `code_out`=16'h5678 and a single `code_update` pulse.
   - `leds_out[8]`=1 and the displays show 'd',5,6,7,8.
3. Enter 1,2,3,4 then confirm with 1,2,3,5.
   - State FAIL, `leds_out[7]`=1, digit displays all '-', `code_out` unchanged, no `code_update`.
4. During ENTER, press with `Sw[3:0]`=4'hC.
   - Count and `leds_out[3:0]` unchanged.
5. Drive `btn_n` low for 3 cycles, then high (a glitch).
   - No capture.
   - A subsequent hold of 4 or more stable cycles captures exactly one digit, at the cycle given in Timing.
6. After 2 confirm digits, drop `Sw[9]`; separately, pulse `rst` low mid-ENTER.
   - Drop `Sw[9]`: next cycle IDLE, `leds_out`=0, `code_out` unchanged.
   - `rst` pulse: `code_out`=16'h1234 immediately.
